// File: rtl/c17_chk_pkg.sv
// Shared definitions for the c17 stream checker: FSM encoding, LFSR feedback
// and the golden c17 reference function.
package c17_chk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;

    // Feedback taps for the 5-bit maximal-length sequence (v[4] ^ v[2]).
    localparam logic [4:0] LFSR_TAPS = 5'b10100;

    localparam int IDX_N1 = 0;
    localparam int IDX_N2 = 1;
    localparam int IDX_N3 = 2;
    localparam int IDX_N6 = 3;
    localparam int IDX_N7 = 4;

    function automatic logic [4:0] lfsr_next(input logic [4:0] v);
        return {v[3:0], ^(v & LFSR_TAPS)};
    endfunction

    // Returns {N22, N23} for one input vector.
    function automatic logic [1:0] c17_golden(input logic [4:0] v);
        logic nand36;
        nand36 = ~(v[IDX_N3] & v[IDX_N6]);
        return {(v[IDX_N1] & v[IDX_N3]) | (v[IDX_N2] & nand36),
                nand36 & (v[IDX_N2] | v[IDX_N7])};
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift line carrying one expected bit plus its valid flag, so a
// check fires exactly DEPTH cycles after the vector was issued.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    output logic out_vld,
    output logic dout,
    output logic pending
);

    localparam logic [DEPTH-1:0] KEEP_MASK = {DEPTH{1'b1}} >> 1;

    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] dat_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | DEPTH'(push);
        end
    end

    always_ff @(posedge clk) begin
        dat_p <= (dat_p << 1) | DEPTH'(din);
    end

    assign out_vld = vld_p[DEPTH-1];
    assign dout    = dat_p[DEPTH-1];
    // Entries still in flight after the one being checked this cycle.
    assign pending = |(vld_p & KEEP_MASK);

endmodule

// File: rtl/c17_stream_checker.sv
// LFSR stimulus generator and per-output latency-aligned response checker for
// the buffer-inserted c17 netlist.
module c17_stream_checker
    import c17_chk_pkg::*;
#(
    parameter int         LAT_N22 = 5,
    parameter int         LAT_N23 = 4,
    parameter int         NUM_VEC = 32,
    parameter logic [4:0] SEED    = 5'h01,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [4:0]       dut_in,
    input  logic             dut_n22,
    input  logic             dut_n23,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_n22_cnt,
    output logic [CNT_W-1:0] err_n23_cnt,
    output logic [CNT_W-1:0] vec_cnt
);

    localparam logic [4:0]       SEED_EFF = (SEED == 5'h00) ? 5'h01 : SEED;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    state_t     state;
    logic [4:0] lfsr;
    logic [7:0] issued;
    logic [1:0] gold;
    logic       issue;
    logic       clr;
    logic       chk22_vld, chk22_exp, pend22;
    logic       chk23_vld, chk23_exp, pend23;

    assign issue = (state == RUN);
    assign clr   = start && ((state == IDLE) || (state == DONE));
    assign gold  = c17_golden(lfsr);

    valid_delay_line #(.DEPTH(LAT_N22)) u_dly_n22 (
        .clk     (clk),
        .rst     (rst),
        .push    (issue),
        .din     (gold[1]),
        .out_vld (chk22_vld),
        .dout    (chk22_exp),
        .pending (pend22)
    );

    valid_delay_line #(.DEPTH(LAT_N23)) u_dly_n23 (
        .clk     (clk),
        .rst     (rst),
        .push    (issue),
        .din     (gold[0]),
        .out_vld (chk23_vld),
        .dout    (chk23_exp),
        .pending (pend23)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dut_in      <= '0;
            lfsr        <= SEED_EFF;
            issued      <= '0;
            vec_cnt     <= '0;
            err_n22_cnt <= '0;
            err_n23_cnt <= '0;
        end else begin
            dut_in <= issue ? lfsr : '0;

            case (state)
                IDLE, DONE: if (start) state <= RUN;
                RUN:        if (issued == 8'(NUM_VEC - 1)) state <= DRAIN;
                DRAIN:      if (!pend22 && !pend23) state <= DONE;
                default:    state <= IDLE;
            endcase

            if (clr) begin
                lfsr        <= SEED_EFF;
                issued      <= '0;
                vec_cnt     <= '0;
                err_n22_cnt <= '0;
                err_n23_cnt <= '0;
            end else begin
                if (issue) begin
                    lfsr    <= lfsr_next(lfsr);
                    issued  <= issued + 8'd1;
                    vec_cnt <= sat_inc(vec_cnt);
                end
                // X on the netlist outputs evaluates false here, outside windows it is never looked at.
                if (chk22_vld && (dut_n22 != chk22_exp)) err_n22_cnt <= sat_inc(err_n22_cnt);
                if (chk23_vld && (dut_n23 != chk23_exp)) err_n23_cnt <= sat_inc(err_n23_cnt);
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_n22_cnt == '0) && (err_n23_cnt == '0);

endmodule

// File: tb/tb_c17_stream_checker.sv
// Bench for c17_stream_checker: three checker configurations, each driving a
// behavioural buffered-c17 netlist with optional fault injection.
module tb_c17_stream_checker;

    localparam int NI      = 3;
    localparam int M_GOLD  = 0;
    localparam int M_RAND  = 1;
    localparam int M_STUCK = 2;
    localparam int M_SKEW  = 3;
    localparam int M_INV   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a  [NI];
    logic [4:0] dut_in_a [NI];
    logic       n22_a    [NI];
    logic       n23_a    [NI];
    logic       busy_a   [NI];
    logic       done_a   [NI];
    logic       pass_a   [NI];
    logic [7:0] e22_a    [NI];
    logic [7:0] e23_a    [NI];
    logic [7:0] vc_a     [NI];
    logic [1:0] e22_2, e23_2, vc_2;

    logic [3:0] p22    [NI];
    logic [2:0] p23    [NI];
    logic       flip22 [NI];
    logic       flip23 [NI];
    int         mode   [NI];

    logic [4:0] exp_vec [0:63];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    c17_stream_checker u0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .dut_in(dut_in_a[0]),
        .dut_n22(n22_a[0]), .dut_n23(n23_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .pass(pass_a[0]), .err_n22_cnt(e22_a[0]), .err_n23_cnt(e23_a[0]), .vec_cnt(vc_a[0])
    );

    c17_stream_checker #(.NUM_VEC(1)) u1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .dut_in(dut_in_a[1]),
        .dut_n22(n22_a[1]), .dut_n23(n23_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .pass(pass_a[1]), .err_n22_cnt(e22_a[1]), .err_n23_cnt(e23_a[1]), .vec_cnt(vc_a[1])
    );

    c17_stream_checker #(.CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start_a[2]), .dut_in(dut_in_a[2]),
        .dut_n22(n22_a[2]), .dut_n23(n23_a[2]), .busy(busy_a[2]), .done(done_a[2]),
        .pass(pass_a[2]), .err_n22_cnt(e22_2), .err_n23_cnt(e23_2), .vec_cnt(vc_2)
    );

    assign e22_a[2] = {6'b0, e22_2};
    assign e23_a[2] = {6'b0, e23_2};
    assign vc_a[2]  = {6'b0, vc_2};

    function automatic logic ref22(input logic [4:0] v);
        logic n1, n2, n3, n6, n7;
        {n7, n6, n3, n2, n1} = v;
        return (n1 & n3) | (n2 & ~(n3 & n6));
    endfunction

    function automatic logic ref23(input logic [4:0] v);
        logic n1, n2, n3, n6, n7;
        {n7, n6, n3, n2, n1} = v;
        return ~(n3 & n6) & (n2 | n7);
    endfunction

    function automatic int nv(input int i);
        return (i == 1) ? 1 : 32;
    endfunction

    function automatic int cmax(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Netlist model: N22 through 4 register levels, N23 through 3, so the
    // checker sees them 5 and 4 cycles after issue.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            p22[i] <= {p22[i][2:0], ref22(dut_in_a[i]) ^ flip22[i]};
            p23[i] <= {p23[i][1:0], ref23(dut_in_a[i]) ^ flip23[i]};
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_net
        assign n22_a[g] = (mode[g] == M_STUCK) ? 1'b0 :
                          (mode[g] == M_SKEW)  ? p22[g][2] : p22[g][3];
        assign n23_a[g] = p23[g][2] ^ (mode[g] == M_INV);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_idle(input int i, input string tag);
        check($sformatf("%s dut_in[%0d]", tag, i), dut_in_a[i], 0);
        check($sformatf("%s busy[%0d]", tag, i), busy_a[i], 0);
        check($sformatf("%s done[%0d]", tag, i), done_a[i], 0);
        check($sformatf("%s pass[%0d]", tag, i), pass_a[i], 0);
        check($sformatf("%s err22[%0d]", tag, i), e22_a[i], 0);
        check($sformatf("%s err23[%0d]", tag, i), e23_a[i], 0);
        check($sformatf("%s vec_cnt[%0d]", tag, i), vc_a[i], 0);
    endtask

    task automatic run(input int i, input int md, input int abort_at, input bit poke_start);
        int  idx, bad22, bad23, x22, x23;
        bit  got;
        mode[i] = md;
        idx = 0; bad22 = 0; bad23 = 0; got = 1'b0;
        start_a[i] = 1'b1;
        @(negedge clk);
        start_a[i] = 1'b0;
        for (int k = 1; k <= 200 && !got; k++) begin
            @(negedge clk);
            flip22[i] = 1'b0;
            flip23[i] = 1'b0;
            start_a[i] = (poke_start && k == 3);
            if (k == 1) check($sformatf("busy[%0d]", i), busy_a[i], 1);
            if (idx < nv(i)) begin
                check($sformatf("dut_in[%0d] v%0d", i, idx), dut_in_a[i], exp_vec[idx]);
                if (md == M_RAND) begin
                    flip22[i] = ($urandom_range(3) == 0);
                    flip23[i] = ($urandom_range(3) == 0);
                end
                bad22 += (md == M_STUCK) ? int'(ref22(exp_vec[idx])) : int'(flip22[i]);
                bad23 += (md == M_INV) ? 1 : int'(flip23[i]);
                idx++;
                if (idx == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check_idle(i, "abort");
                    return;
                end
            end
            got = done_a[i];
            if (got) check($sformatf("done latency[%0d]", i), k, nv(i) + 5);
        end
        start_a[i] = 1'b0;
        check($sformatf("done reached[%0d]", i), done_a[i], 1);
        x22 = sat(bad22, cmax(i));
        x23 = sat(bad23, cmax(i));
        check($sformatf("vec_cnt[%0d]", i), vc_a[i], sat(nv(i), cmax(i)));
        if (md == M_SKEW) begin
            check($sformatf("err22 nonzero[%0d]", i), (e22_a[i] != 0), 1);
            x22 = 1;
        end else begin
            check($sformatf("err22[%0d]", i), e22_a[i], x22);
        end
        check($sformatf("err23[%0d]", i), e23_a[i], x23);
        check($sformatf("pass[%0d]", i), pass_a[i], (x22 == 0 && x23 == 0));
        repeat (2) @(negedge clk);
        check($sformatf("done held[%0d]", i), done_a[i], 1);
    endtask

    initial begin
        logic [4:0] v;
        v = 5'h01;
        for (int k = 0; k < 64; k++) begin
            exp_vec[k] = v;
            v = {v[3:0], v[4] ^ v[2]};
        end
        for (int i = 0; i < NI; i++) begin
            start_a[i] = 1'b0;
            flip22[i]  = 1'b0;
            flip23[i]  = 1'b0;
            mode[i]    = M_GOLD;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check_idle(i, "reset");
        rst = 1'b0;
        repeat ($urandom_range(4, 1)) @(negedge clk);

        run(0, M_GOLD, 0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(3)) @(negedge clk);
            run(0, M_RAND, 0, 1'b0);
        end
        run(0, M_STUCK, 0, 1'b0);
        run(0, M_SKEW, 0, 1'b0);
        run(0, M_GOLD, 10, 1'b0);
        run(0, M_GOLD, 0, 1'b0);

        rst = 1'b1;
        start_a[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_a[0] = 1'b0;
        check_idle(0, "rst+start");

        run(1, M_GOLD, 0, 1'b1);
        run(1, M_RAND, 0, 1'b0);
        run(2, M_INV, 0, 1'b0);
        run(2, M_RAND, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/c17_stream_checker.md
Name: c17_stream_checker

Overview:
- Self-checking stimulus/response harness for the path-balanced, clocked (buffer-inserted) c17 netlist.
- Transmit side: drives the netlist primary inputs with an LFSR vector stream, one vector per cycle.
- Receive side: captures the two netlist outputs at their individual pipeline depths and compares them against a golden c17 model.
- Sits beside the buffered netlist in gate-level and post-insertion regression; reports per-output mismatch counts and pass/fail.

Parameters:
- LAT_N22, 5, clock cycles from vector issue to valid N22 (logic depth of the N22 cone after buffer insertion)
- LAT_N23, 4, clock cycles from vector issue to valid N23 (N23 cone is one level shallower; outputs are not mutually balanced)
- NUM_VEC, 32, vectors issued per run, range 1..255
- SEED, 5'h01, LFSR seed; a value of 0 is replaced by 5'h01
- CNT_W, 8, width of the mismatch and issued-vector counters (saturating)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- dut_in  out  5  netlist inputs, bit order {N7,N6,N3,N2,N1}
- dut_n22  in  1  netlist output N22
- dut_n23  in  1  netlist output N23
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; held until the next start or rst
- pass  out  1  valid only while done; 1 when both mismatch counts are 0
- err_n22_cnt  out  CNT_W  N22 mismatch count, saturating
- err_n23_cnt  out  CNT_W  N23 mismatch count, saturating
- vec_cnt  out  CNT_W  vectors issued in the current run

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - dut_in=0, busy=0, done=0, pass=0, all counters 0, LFSR=SEED, all delay-line valid bits 0.
  - A reset during RUN or DRAIN aborts the run; no partial result is reported.
- Golden model:
  - N22 = (N1&N3) | (N2 & ~(N3&N6))
  - N23 = ~(N3&N6) & (N2|N7)
  - Evaluated on the vector being issued in the same cycle.
- LFSR:
  - 5-bit maximal length, next = {v[3:0], v[4]^v[2]}.
  - Advances once per issued vector.
  - Issue order from seed 01: 5'h01, 5'h02, 5'h04, 5'h09, ...
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Counters clear and LFSR reloads SEED in that same cycle.
  - RUN: each cycle, dut_in is registered with the current LFSR value, vec_cnt increments, and the expected bits plus a valid bit are pushed into two delay lines of depth LAT_N22 and LAT_N23. RUN -> DRAIN in the cycle the NUM_VEC-th vector is issued.
  - DRAIN: dut_in holds 0 and nothing new is pushed. DRAIN -> DONE once both delay lines hold no valid entries, i.e. max(LAT_N22, LAT_N23) cycles after the last issue.
  - DONE: pass = (err_n22_cnt==0) && (err_n23_cnt==0). start re-enters RUN and clears the counters. start during RUN or DRAIN is ignored.
- Check timing:
  - A vector driven on dut_in in cycle t has N22 sampled at cycle t+LAT_N22 and N23 at cycle t+LAT_N23.
  - A check happens only when the corresponding delay-line valid bit is set.
  - A mismatch increments the matching counter; counters saturate at 2^CNT_W-1.
  - Outputs outside check windows are don't-care, including X from the netlist in the first cycles after reset.
- Simultaneous events:
  - N22 and N23 checks for different vectors can land in the same cycle; they are independent, and both counters may increment together.
  - start and rst in the same cycle: rst wins.
- LFSR period is 31. NUM_VEC > 31 wraps the sequence, which is legal. Vector 5'h00 is never issued.

Decomposition:
- Shared package c17_chk_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - LFSR tap constant
  - input-bit index constants (N1=0 .. N7=4)
  - the golden c17 function
- One sub-module, valid_delay_line (parameter DEPTH; 1-bit data plus valid), instantiated once per output.

Test Plan:
- Golden DUT model, default parameters, start -> first vectors 5'h01, 5'h02, 5'h04; expected N22 0,1,0 and N23 0,1,0; after 32+5 cycles done=1, pass=1, vec_cnt=32, both error counts 0.
- DUT N22 stuck at 0 -> err_n22_cnt equals the number of issued vectors with golden N22=1, err_n23_cnt=0, pass=0.
- DUT N22 balanced at depth 4 instead of 5 (off-by-one skew) -> nonzero err_n22_cnt, err_n23_cnt=0.
- rst asserted for 1 cycle at the 10th vector of RUN -> IDLE, all outputs 0; a following start yields a clean pass.
- NUM_VEC=1 -> RUN lasts 1 cycle, DRAIN 5 cycles, done on cycle 7 after start; start pulsed during DRAIN is ignored.
- CNT_W=2 with DUT N23 inverted -> err_n23_cnt saturates at 3, with no wrap to 0.
